dll_code_ctrl: RTL

- Delay-code controller directly downstream of the FMDLL phase detector.
- Consumes the detector's COMP decision once per compare window.
- Runs a W-bit successive-approximation search followed by ±1 tracking.
- Drives the delay-line code Q / Q_next and reports lock plus lead/lag status.

---
 rtl/fmdll_pkg.sv | 17 +
 rtl/dll_lock_det.sv | 51 +++++
 rtl/dll_code_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: controller state encoding, default code width,
// mid-code start point and phase-detector polarity.
package fmdll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAR   = 2'd1,
        TRACK = 2'd2
    } dll_state_e;

    localparam int CODE_W = 10;
    localparam logic [CODE_W-1:0] MID_CODE = {1'b1, {(CODE_W-1){1'b0}}};

    // COMP value the PD produces when the delay is too long (clk_out lags).
    localparam logic COMP_LAG = 1'b1;

endpackage

// File: rtl/dll_lock_det.sv
// Lock detector: counts consecutive direction reversals (lock) and
// consecutive same-direction steps (unlock) while tracking.
module dll_lock_det #(
    parameter int LOCK_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic dec_vld,
    input  logic dir,
    input  logic track,
    output logic lock
);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

    logic [CW-1:0] rev_cnt, run_cnt, rev_inc, run_inc;
    logic          prev_dir;

    assign rev_inc = (rev_cnt == CNT_MAX) ? rev_cnt : rev_cnt + 1'b1;
    assign run_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;

    // Direction memory follows SAR decisions too, so the first TRACK step
    // is compared against the final SAR decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_cnt  <= '0;
            run_cnt  <= '0;
            lock     <= 1'b0;
            prev_dir <= 1'b0;
        end else if (clr) begin
            rev_cnt <= '0;
            run_cnt <= '0;
            lock    <= 1'b0;
        end else if (dec_vld) begin
            prev_dir <= dir;
            if (track) begin
                if (dir != prev_dir) begin
                    rev_cnt <= rev_inc;
                    run_cnt <= '0;
                    if (rev_inc == CNT_MAX) lock <= 1'b1;
                end else begin
                    run_cnt <= run_inc;
                    rev_cnt <= '0;
                    if (run_inc == CNT_MAX) lock <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dll_code_ctrl.sv
// FMDLL delay-code controller: SAR search from mid-code, then +/-1 tracking,
// with settle gating of PD decisions and reversal-based lock detection.
module dll_code_ctrl
    import fmdll_pkg::*;
#(
    parameter int W        = CODE_W,
    parameter int SETTLE   = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic         clk_ext,
    input  logic         Reset_CTRL,
    input  logic         COMP,
    input  logic         cmp_valid,
    input  logic         restart,
    output logic [W-1:0] Q,
    output logic [W-1:0] Q_next,
    output logic         lock,
    output logic         sar_done,
    output logic         lead,
    output logic         lag
);
    localparam int IW  = $clog2(W);
    localparam int SCW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [W-1:0]   MID      = {1'b1, {(W-1){1'b0}}};
    localparam logic [IW-1:0]  IDX_TOP  = IW'(W - 1);
    localparam logic [SCW-1:0] SETTLE_V = SCW'(SETTLE);

    dll_state_e     state, state_n;
    logic [W-1:0]   q_n, q_dec;
    logic [IW-1:0]  idx, idx_n;
    logic [SCW-1:0] settle_cnt, settle_n;
    logic           sar_done_n, lead_n, lag_n;
    logic           settle_zero, accept;

    assign settle_zero = (settle_cnt == '0);
    assign accept      = cmp_valid && settle_zero && !restart && (state != IDLE);
    assign Q_next      = (state != IDLE && settle_zero) ? q_dec : Q;

    // Candidate code for the current COMP, independent of cmp_valid.
    always_comb begin
        q_dec = Q;
        unique case (state)
            SAR: begin
                if (COMP == COMP_LAG) q_dec[idx] = 1'b0;
                if (idx != '0) q_dec[idx - 1'b1] = 1'b1;
            end
            TRACK: begin
                if (COMP == COMP_LAG) begin
                    if (Q != '0) q_dec = Q - 1'b1;
                end else if (Q != '1) begin
                    q_dec = Q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state;
        q_n        = Q;
        idx_n      = idx;
        settle_n   = settle_cnt;
        sar_done_n = sar_done;
        lead_n     = lead;
        lag_n      = lag;
        if (restart) begin
            state_n    = SAR;
            q_n        = MID;
            idx_n      = IDX_TOP;
            settle_n   = SETTLE_V;
            sar_done_n = 1'b0;
        end else if (state == IDLE) begin
            state_n = SAR;
        end else if (cmp_valid) begin
            if (!settle_zero) begin
                settle_n = settle_cnt - 1'b1;
            end else begin
                q_n    = q_dec;
                lead_n = (COMP != COMP_LAG);
                lag_n  = (COMP == COMP_LAG);
                // Saturated TRACK steps leave the line untouched: no reload.
                if (q_dec != Q) settle_n = SETTLE_V;
                if (state == SAR) begin
                    if (idx == '0) begin
                        state_n    = TRACK;
                        sar_done_n = 1'b1;
                    end else begin
                        idx_n = idx - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_ext or posedge Reset_CTRL) begin
        if (Reset_CTRL) begin
            state      <= IDLE;
            Q          <= MID;
            idx        <= IDX_TOP;
            settle_cnt <= SETTLE_V;
            sar_done   <= 1'b0;
            lead       <= 1'b0;
            lag        <= 1'b0;
        end else begin
            state      <= state_n;
            Q          <= q_n;
            idx        <= idx_n;
            settle_cnt <= settle_n;
            sar_done   <= sar_done_n;
            lead       <= lead_n;
            lag        <= lag_n;
        end
    end

    dll_lock_det #(.LOCK_CNT(LOCK_CNT)) u_lock_det (
        .clk     (clk_ext),
        .rst     (Reset_CTRL),
        .clr     (restart),
        .dec_vld (accept),
        .dir     (COMP),
        .track   (state == TRACK),
        .lock    (lock)
    );

endmodule
